pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: combines stage stall requests, sequences multi-cycle EX ops, and issues redirect flushes.
// Latency: stall is combinational from the requests; flush/new_pc/mc_busy/mc_done appear the cycle after their trigger.
// Backpressure: mc_start is dropped outside IDLE; flush_req always wins and aborts any multi-cycle op in flight.
module pipe_ctrl #(
    parameter int MC_LEN_W    = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_from_id,
    input  logic                   stallreq_from_ex,
    input  logic                   mc_start,
    input  logic [MC_LEN_W-1:0]    mc_len,
    input  logic                   flush_req,
    input  logic [31:0]            flush_pc,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [31:0]            new_pc,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MC    = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] STALL_ID = 6'b000111;
    localparam logic [5:0] STALL_EX = 6'b001111;

    state_t                state_q, state_d;
    logic [MC_LEN_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [MC_LEN_W-1:0]   mc_len_eff;
    logic                  last_mc;
    logic [5:0]            mc_stall;

    // A zero length still occupies one MC cycle so mc_done is always seen.
    assign mc_len_eff = (mc_len == '0) ? MC_LEN_W'(1) : mc_len;
    assign last_mc    = (mc_cnt_q == MC_LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mc_cnt_q  <= '0;
            new_pc    <= 32'h0000_0000;
            stall_cnt <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (flush_req) begin
                new_pc <= flush_pc;
            end
            if (stall[0] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        if (flush_req) begin
            state_d  = FLUSH;
            mc_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mc_start) begin
                        state_d  = MC;
                        mc_cnt_d = mc_len_eff;
                    end
                end
                MC: begin
                    mc_cnt_d = mc_cnt_q - 1'b1;
                    if (last_mc) begin
                        state_d = IDLE;
                    end
                end
                FLUSH:   state_d = IDLE;
                default: begin
                    state_d  = IDLE;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        flush    = (state_q == FLUSH);
        mc_busy  = (state_q == MC);
        mc_done  = (state_q == MC) && last_mc;
        mc_stall = (mc_busy && !last_mc) ? STALL_EX : 6'b000000;
        stall    = mc_stall;
        if (stallreq_from_id) stall = stall | STALL_ID;
        if (stallreq_from_ex) stall = stall | STALL_EX;
        // Requests are combinational, so reset must mask them explicitly.
        if (rst || flush) stall = 6'b000000;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written saturation sequence, then randomized run against a reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_req, ex_req, mc_start, flush_req;
    logic [5:0]  mc_len;
    logic [31:0] flush_pc;
    logic [5:0]  stall, stall4;
    logic        flush, mc_busy, mc_done, flush4, busy4, done4;
    logic [31:0] new_pc, new_pc4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
        .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy),
        .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.MC_LEN_W(6), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallreq_from_id(id_req), .stallreq_from_ex(ex_req),
        .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4), .mc_busy(busy4),
        .mc_done(done4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        bit          rst, id, ex, ms;
        logic [5:0]  len;
        bit          fr;
        logic [31:0] fpc;
        logic [5:0]  st;
        bit          fl, bz, dn;
        logic [31:0] pc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit i, input bit e, input bit ms, input logic [5:0] l,
                         input bit fr, input logic [31:0] fpc);
        rst = r; id_req = i; ex_req = e; mc_start = ms; mc_len = l; flush_req = fr; flush_pc = fpc;
    endtask

    // Reference model state: remaining MC cycles rather than an encoded FSM.
    bit          m_flush;
    int          m_rem;
    logic [31:0] m_pc;
    int          m_c16, m_c4;

    initial begin
        //                  rst id ex ms len fr fpc            stall    fl bz dn pc            cnt
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h0,      16'd0}); // r0 reset state
        vecs.push_back('{0,0,0,1,6'd4,0,32'h0,          6'h00,0,0,0,32'h0,      16'd0}); // r1 start len4
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h0,      16'd0});
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h0,      16'd1});
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h0,      16'd2});
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,1,1,32'h0,      16'd3}); // r5 done
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h0,      16'd3});
        vecs.push_back('{0,0,0,1,6'd0,0,32'h0,          6'h00,0,0,0,32'h0,      16'd3}); // r7 len0
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,1,1,32'h0,      16'd3});
        vecs.push_back('{0,0,0,1,6'd1,0,32'h0,          6'h00,0,0,0,32'h0,      16'd3}); // r9 len1
        vecs.push_back('{0,1,0,0,6'd0,0,32'h0,          6'h07,0,1,1,32'h0,      16'd3}); // r10 id in done cycle
        vecs.push_back('{0,1,1,0,6'd0,0,32'h0,          6'h0F,0,0,0,32'h0,      16'd4}); // r11 id+ex
        vecs.push_back('{0,0,0,1,6'd5,0,32'h0,          6'h00,0,0,0,32'h0,      16'd5}); // r12 start len5
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h0,      16'd5});
        vecs.push_back('{0,0,0,0,6'd0,1,32'h0000_0100,  6'h0F,0,1,0,32'h0,      16'd6}); // r14 flush in MC cycle 2
        vecs.push_back('{0,1,1,1,6'd3,0,32'h0,          6'h00,1,0,0,32'h100,    16'd7}); // r15 flush cycle
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h100,    16'd7}); // r16 mc_start ignored
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h100,    16'd7});
        vecs.push_back('{0,0,0,1,6'd5,0,32'h0,          6'h00,0,0,0,32'h100,    16'd7}); // r18 start len5
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h100,    16'd7});
        vecs.push_back('{1,1,1,1,6'd3,1,32'h0000_0200,  6'h00,0,1,0,32'h100,    16'd8}); // r20 reset in MC cycle 2
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h0,      16'd0});
        vecs.push_back('{0,0,0,1,6'd2,0,32'h0,          6'h00,0,0,0,32'h0,      16'd0}); // r22 start after reset
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h0F,0,1,0,32'h0,      16'd0});
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,1,1,32'h0,      16'd1});
        vecs.push_back('{0,0,0,0,6'd0,0,32'h0,          6'h00,0,0,0,32'h0,      16'd1});

        drive(1, 0, 0, 0, 6'd0, 0, 32'h0);
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].id, vecs[i].ex, vecs[i].ms, vecs[i].len, vecs[i].fr, vecs[i].fpc);
            #1;
            chk("stall",     i, 32'(stall),     32'(vecs[i].st));
            chk("flush",     i, 32'(flush),     32'(vecs[i].fl));
            chk("mc_busy",   i, 32'(mc_busy),   32'(vecs[i].bz));
            chk("mc_done",   i, 32'(mc_done),   32'(vecs[i].dn));
            chk("new_pc",    i, new_pc,         vecs[i].pc);
            chk("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].cnt));
        end

        // Saturation: ex request held for 20 cycles from a clean reset.
        @(negedge clk);
        drive(1, 0, 0, 0, 6'd0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 0, 6'd0, 0, 32'h0);
        repeat (20) @(negedge clk);
        drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
        #1;
        chk("sat_cnt4",  100, 32'(stall_cnt4), 32'h0000_000F);
        chk("sat_cnt16", 100, 32'(stall_cnt),  32'd20);
        @(negedge clk);
        drive(0, 0, 1, 0, 6'd0, 0, 32'h0);
        @(negedge clk);
        #1;
        chk("sat_hold4", 101, 32'(stall_cnt4), 32'h0000_000F);

        // Back-to-back flush: FLUSH re-entered, new_pc follows the latest target.
        @(negedge clk);
        drive(0, 0, 0, 0, 6'd0, 1, 32'h0000_0A00);
        @(negedge clk);
        drive(0, 0, 0, 0, 6'd0, 1, 32'h0000_0B00);
        #1;
        chk("b2b_flush1", 102, 32'(flush), 32'd1);
        chk("b2b_pc1",    102, new_pc,     32'h0000_0A00);
        @(negedge clk);
        drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
        #1;
        chk("b2b_flush2", 103, 32'(flush), 32'd1);
        chk("b2b_pc2",    103, new_pc,     32'h0000_0B00);

        // Randomized run against the reference model.
        @(negedge clk);
        drive(1, 0, 0, 0, 6'd0, 0, 32'h0);
        m_flush = 0; m_rem = 0; m_pc = 32'h0; m_c16 = 0; m_c4 = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  e_st;
            @(negedge clk);
            drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 9)), ($urandom_range(0, 11) == 0),
                  $urandom);
            #1;
            e_st = 6'h00;
            if (!rst && !m_flush) begin
                if (id_req)     e_st = e_st | 6'h07;
                if (ex_req)     e_st = e_st | 6'h0F;
                if (m_rem > 1)  e_st = e_st | 6'h0F;
            end
            chk("rnd_stall",   n, 32'(stall),      32'(e_st));
            chk("rnd_flush",   n, 32'(flush),      32'(m_flush));
            chk("rnd_busy",    n, 32'(mc_busy),    32'(m_rem > 0));
            chk("rnd_done",    n, 32'(mc_done),    32'(m_rem == 1));
            chk("rnd_pc",      n, new_pc,          m_pc);
            chk("rnd_cnt",     n, 32'(stall_cnt),  32'(m_c16));
            chk("rnd_cnt4",    n, 32'(stall_cnt4), 32'(m_c4));
            if (rst) begin
                m_flush = 0; m_rem = 0; m_pc = 32'h0; m_c16 = 0; m_c4 = 0;
            end else begin
                if (e_st[0]) begin
                    if (m_c16 < 65535) m_c16++;
                    if (m_c4 < 15)     m_c4++;
                end
                if (flush_req) begin
                    m_flush = 1; m_pc = flush_pc; m_rem = 0;
                end else if (m_flush) begin
                    m_flush = 0;
                end else if (m_rem > 0) begin
                    m_rem--;
                end else if (mc_start) begin
                    m_rem = (mc_len == 0) ? 1 : int'(mc_len);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
